// File: rtl/fir_serial_mac_if.sv
// Sample/coefficient/result signal bundle for fir_serial_mac.
// master drives samples and coefficient writes; slave is the filter.
interface fir_serial_mac_if #(
  parameter int WIDTH = 16,
  parameter int NTAPS = 17,
  parameter int CW    = 16
);
  localparam int AW = $clog2(NTAPS);

  logic                    coef_we;
  logic [AW-1:0]           coef_addr;
  logic signed [CW-1:0]    coef_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;

  modport master (
    output coef_we, coef_addr, coef_data, in_valid, in_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, in_valid, in_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_serial_mac.sv
// Serial FIR filter: one shared multiply-accumulate evaluates one tap per cycle
// over a circular sample buffer, then rounds and saturates the result.
module fir_serial_mac #(
  parameter int WIDTH = 16,
  parameter int NTAPS = 17,
  parameter int CW    = 16,
  parameter int FRAC  = 15
) (
  input logic            clk,
  input logic            rst,
  fir_serial_mac_if.slave bus
);
  localparam int AW   = $clog2(NTAPS);
  localparam int PW   = WIDTH + CW;
  localparam int ACCW = WIDTH + CW + AW;
  localparam int RW   = ACCW + 1;
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]           tap_q, tap_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [WIDTH-1:0] samp_q [NTAPS];
  logic signed [WIDTH-1:0] samp_d [NTAPS];
  logic signed [CW-1:0]    coef_q [NTAPS];
  logic signed [CW-1:0]    coef_d [NTAPS];
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_data_q, out_data_d;

  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc_sum;
  logic signed [RW-1:0]    half, rnd, shr, max_v, min_v;
  logic signed [WIDTH-1:0] sat;
  logic                    coef_ok;

  assign coef_ok = 32'(bus.coef_addr) < NTAPS;

  always_comb begin
    prod    = samp_q[rd_ptr_q] * coef_q[tap_q];
    acc_sum = acc_q + {{AW{prod[PW-1]}}, prod};

    // Round half up on the final sum, then clamp to the output range.
    half          = '0;
    half[FRAC-1]  = 1'b1;
    rnd           = $signed({acc_sum[ACCW-1], acc_sum}) + half;
    shr           = rnd >>> FRAC;
    max_v         = '0;
    max_v[WIDTH-2:0] = '1;
    min_v         = '1;
    min_v[WIDTH-2:0] = '0;
    if (shr > max_v)      sat = max_v[WIDTH-1:0];
    else if (shr < min_v) sat = min_v[WIDTH-1:0];
    else                  sat = shr[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    samp_d      = samp_q;
    coef_d      = coef_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    case (state_q)
      IDLE: begin
        if (bus.coef_we && coef_ok) coef_d[bus.coef_addr] = bus.coef_data;
        if (bus.in_valid) begin
          samp_d[wr_ptr_q] = bus.in_data;
          rd_ptr_d = wr_ptr_q;
          wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
          tap_d    = '0;
          acc_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (tap_q == LAST) begin
          tap_d       = '0;
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_data_d  = sat;
        end else begin
          tap_d = tap_q + AW'(1);
          // Walk backwards from the newest sample to reach x[n-k].
          rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - AW'(1);
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      samp_q      <= '{default: '0};
      coef_q      <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      samp_q      <= samp_d;
      coef_q      <= coef_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac with WIDTH=16, NTAPS=17, CW=16, FRAC=15.
module tb_fir_serial_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fir_serial_mac_if #(.WIDTH(16), .NTAPS(17), .CW(16)) ifc ();

  fir_serial_mac #(.WIDTH(16), .NTAPS(17), .CW(16), .FRAC(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic load_coef(input int addr, input int data);
    @(negedge clk);
    ifc.coef_we   = 1'b1;
    ifc.coef_addr = 5'(addr);
    ifc.coef_data = 16'(data);
    @(negedge clk);
    ifc.coef_we = 1'b0;
  endtask

  // Offer one sample, optionally with a same-cycle coefficient write, and
  // check the result arrives 18 cycles after acceptance.
  task automatic send(input string tag, input int x, input bit chk_y, input int exp_y,
                      input bit cw, input int ca, input int cd);
    int cnt;
    @(negedge clk);
    check({tag, "_rdy"}, int'(ifc.in_ready), 1);
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 16'(x);
    ifc.coef_we   = cw;
    ifc.coef_addr = 5'(ca);
    ifc.coef_data = 16'(cd);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.coef_we  = 1'b0;
    cnt = 1;
    while (!ifc.out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_lat"}, cnt, 18);
    if (chk_y) check({tag, "_y"}, int'($signed(ifc.out_data)), exp_y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_c [$];
    int n_out, n_busy, cnt;

    ifc.coef_we = 1'b0; ifc.coef_addr = '0; ifc.coef_data = '0;
    ifc.in_valid = 1'b0; ifc.in_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy",  int'(ifc.in_ready), 1);
    check("rst_ov",   int'(ifc.out_valid), 0);
    check("rst_data", int'($signed(ifc.out_data)), 0);

    // All-zero coefficients
    send("zero", 1234, 1'b1, 0, 1'b0, 0, 0);
    @(negedge clk);
    check("pulse_end", int'(ifc.out_valid), 0);

    // Impulse response of h[k]=1024*(k+1)
    reset_dut();
    for (int k = 0; k < 17; k++) load_coef(k, 1024 * (k + 1));
    for (int n = 0; n < 17; n++)
      send($sformatf("imp%0d", n), (n == 0) ? 16384 : 0, 1'b1, 512 * (n + 1), 1'b0, 0, 0);

    // Rounding, with h[0] written in the same cycle as the first sample
    reset_dut();
    send("rnd_p1", 1,  1'b1, 1, 1'b1, 0, 16384);
    send("rnd_m1", -1, 1'b1, 0, 1'b0, 0, 0);
    send("rnd_p3", 3,  1'b1, 2, 1'b0, 0, 0);
    // Out-of-range write must not disturb anything
    load_coef(17, 12345);
    send("oor", 3, 1'b1, 2, 1'b0, 0, 0);

    // Saturation
    for (int k = 0; k < 17; k++) load_coef(k, 32767);
    for (int n = 0; n < 17; n++)
      send($sformatf("satp%0d", n), 32767, 1'b1, 32767, 1'b0, 0, 0);
    for (int n = 0; n < 17; n++)
      send($sformatf("satn%0d", n), -32768, (n == 16), -32768, 1'b0, 0, 0);

    // Throughput with in_valid held high; coefficient writes during MAC dropped
    reset_dut();
    load_coef(0, 16384);
    n_out = 0; n_busy = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ifc.in_valid  = 1'b1;
      ifc.in_data   = 16'sd2;
      ifc.coef_we   = (c >= 3 && c <= 15);
      ifc.coef_addr = '0;
      ifc.coef_data = '0;
      if (ifc.in_ready) acc_c.push_back(c);
      else n_busy++;
      if (ifc.out_valid) begin
        n_out++;
        check("thr_rdy_out", int'(ifc.in_ready), 0);
        check("thr_y", int'($signed(ifc.out_data)), 1);
      end
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.coef_we  = 1'b0;
    check("thr_accepts", acc_c.size(), 6);
    check("thr_outs", n_out, 5);
    check("thr_busy", n_busy, 94);
    for (int i = 1; i < acc_c.size(); i++)
      check($sformatf("thr_gap%0d", i), acc_c[i] - acc_c[i-1], 19);
    cnt = 0;
    while (!ifc.out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_ov", int'(ifc.out_valid), 1);
    check("drain_y", int'($signed(ifc.out_data)), 1);

    // Reset at MAC cycle 8 aborts the pass
    @(negedge clk);
    @(negedge clk);
    check("abort_rdy0", int'(ifc.in_ready), 1);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 16'sd5;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_out = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ifc.out_valid) n_out++;
    end
    check("abort_no_ov", n_out, 0);
    check("abort_rdy", int'(ifc.in_ready), 1);
    send("abort_next", 5, 1'b1, 0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_serial_mac.md
FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits, signed two's complement.
REQ-002 Parameter NTAPS, default 17, tap count, legal range 2..64.
REQ-003 Parameter CW, default 16, coefficient width in bits, signed.
REQ-004 Parameter FRAC, default 15, number of fractional coefficient bits removed at output.
REQ-005 Derived AW = clog2(NTAPS); accumulator width ACCW = WIDTH+CW+AW.
REQ-006 clk  in  1  clock; all state SHALL change on the rising edge only.
REQ-007 rst  in  1  reset: rst, synchronous, active-high; clock clk.
REQ-008 coef_we  in  1  coefficient write strobe.
REQ-009 coef_addr  in  AW  coefficient index k (tap applied to x[n-k]).
REQ-010 coef_data  in  CW  signed coefficient value.
REQ-011 in_valid  in  1  input sample offered.
REQ-012 in_ready  out  1  block can accept a sample this cycle.
REQ-013 in_data  in  WIDTH  signed input sample.
REQ-014 out_valid  out  1  one-cycle pulse marking a new out_data.
REQ-015 out_data  out  WIDTH  signed filtered sample, held between pulses.

Function
REQ-016 The block SHALL compute y[n] = sum over k=0..NTAPS-1 of h[k]*x[n-k] with one shared multiplier-accumulator, one tap per cycle.
REQ-017 Samples SHALL be stored in an NTAPS-deep circular buffer with write pointer wrapping from NTAPS-1 to 0; no sample shifting.
REQ-018 Coefficients SHALL be held in an NTAPS-entry register file written only via coef_we.
REQ-019 FSM states: IDLE, MAC, OUT.
REQ-020 IDLE: in_ready=1; on in_valid, store in_data at write pointer, advance pointer, clear accumulator, go to MAC.
REQ-021 MAC: exactly NTAPS cycles, tap counter 0..NTAPS-1, acc += h[k]*x[n-k] at full ACCW precision; then go to OUT.
REQ-022 OUT: one cycle, out_valid=1, out_data updated; then go to IDLE.
REQ-023 in_ready SHALL be 0 in MAC and OUT; in_valid there SHALL be ignored (no sample stored).
REQ-024 Sample accepted in cycle T SHALL produce out_valid in cycle T+NTAPS+1; max throughput one sample per NTAPS+2 cycles.
REQ-025 Output: r = acc + 2^(FRAC-1) (round half up), then arithmetic shift right by FRAC.
REQ-026 r above 2^(WIDTH-1)-1 SHALL saturate to 2^(WIDTH-1)-1; below -2^(WIDTH-1) SHALL saturate to -2^(WIDTH-1).
REQ-027 coef_we SHALL be honoured only in IDLE; writes in MAC or OUT SHALL be dropped silently.
REQ-028 coef_we and in_valid in the same IDLE cycle: write SHALL take effect and be used by the MAC pass that cycle starts.
REQ-029 Out-of-range coef_addr (>= NTAPS) SHALL be ignored.

Reset
REQ-030 On rst: FSM=IDLE, write pointer=0, tap counter=0, accumulator=0.
REQ-031 On rst: all sample buffer entries=0 and all coefficients=0.
REQ-032 Reset values: in_ready=1, out_valid=0, out_data=0.
REQ-033 rst asserted mid-MAC SHALL abort the pass; no out_valid for that sample.

Verification (WIDTH=16, NTAPS=17, CW=16, FRAC=15)
REQ-034 Reset then idle -> in_ready=1, out_valid=0, out_data=0; a sample with all coefficients zero -> out_data=0 at T+18.
REQ-035 Load h[k]=1024*(k+1); input 16384 then 16 zeros -> outputs 512,1024,...,8704, each out_valid exactly 18 cycles after its accept.
REQ-036 h[0]=16384, others 0; input 1 -> out_data=1; input -1 -> out_data=0; input 3 -> out_data=2 (round half up).
REQ-037 All h=32767; 17 samples of 32767 -> out_data=32767; 17 samples of -32768 -> out_data=-32768 (saturation).
REQ-038 in_valid held high 100 cycles -> exactly one accept per 19 cycles; in_ready low during MAC and OUT; coef_we during MAC leaves coefficients unchanged.
REQ-039 rst pulsed at MAC cycle 8 -> no out_valid follows; next sample with zero coefficients -> out_data=0.
